// File: rtl/morse_symbol_decoder.sv
// Morse symbol decoder: times keyed pulses and gaps, classifies dot/dash/invalid
// and emits completed letter codes. Optional input glitch filter: MORSE_GLITCH_FILTER_EN.
module morse_symbol_decoder #(
    parameter int CNT_W      = 8,
    parameter int DOT_MAX    = 1,
    parameter int DASH_MIN   = 3,
    parameter int LETTER_GAP = 3,
    parameter int MAX_SYM    = 6
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             I,
    output logic                             pulse_start,
    output logic                             dot,
    output logic                             dash,
    output logic                             sym_err,
    output logic                             letter_valid,
    output logic [MAX_SYM-1:0]               letter_bits,
    output logic [$clog2(MAX_SYM+1)-1:0]     letter_len,
    output logic                             letter_err
);

    localparam int LEN_W = $clog2(MAX_SYM + 1);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DOT_MAX_C  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(LETTER_GAP - 1);
    localparam logic [LEN_W-1:0] SYM_FULL   = LEN_W'(MAX_SYM);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   pulse_cnt;
    logic [CNT_W-1:0]   gap_cnt;
    logic [MAX_SYM-1:0] sym_buf;
    logic [LEN_W-1:0]   sym_cnt;
    logic               let_err;
    logic               i_q;

    logic               is_dot;
    logic               is_dash;
    logic               buf_full;
    logic [MAX_SYM-1:0] sym_mask;

`ifdef MORSE_GLITCH_FILTER_EN
    logic i_s1;
    logic i_s2;

    // Qualified input only follows the synchronised input once two samples agree
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            i_s1 <= 1'b0;
            i_s2 <= 1'b0;
            i_q  <= 1'b0;
        end else begin
            i_s1 <= I;
            i_s2 <= i_s1;
            if (i_s1 == i_s2) begin
                i_q <= i_s2;
            end
        end
    end
`else
    always_comb begin
        i_q = I;
    end
`endif

    always_comb begin
        pulse_start = ((state == IDLE) || (state == LOW)) && i_q;
    end

    // A saturated pulse counter is still >= DASH_MIN, so it classifies as dash
    always_comb begin
        is_dot   = (pulse_cnt <= DOT_MAX_C);
        is_dash  = (pulse_cnt >= DASH_MIN_C);
        buf_full = (sym_cnt == SYM_FULL);
        sym_mask = MAX_SYM'(is_dash) << sym_cnt;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            pulse_cnt    <= '0;
            gap_cnt      <= '0;
            sym_buf      <= '0;
            sym_cnt      <= '0;
            let_err      <= 1'b0;
            dot          <= 1'b0;
            dash         <= 1'b0;
            sym_err      <= 1'b0;
            letter_valid <= 1'b0;
            letter_bits  <= '0;
            letter_len   <= '0;
            letter_err   <= 1'b0;
        end else begin
            dot          <= 1'b0;
            dash         <= 1'b0;
            sym_err      <= 1'b0;
            letter_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_q) begin
                        state     <= HIGH;
                        pulse_cnt <= CNT_ONE;
                    end
                end

                HIGH: begin
                    if (i_q) begin
                        if (pulse_cnt != CNT_MAX) begin
                            pulse_cnt <= pulse_cnt + CNT_ONE;
                        end
                    end else begin
                        if (is_dot || is_dash) begin
                            dot  <= is_dot;
                            dash <= is_dash;
                            // A full buffer drops the symbol but still strobes it
                            if (buf_full) begin
                                let_err <= 1'b1;
                            end else begin
                                sym_buf <= sym_buf | sym_mask;
                                sym_cnt <= sym_cnt + LEN_W'(1);
                            end
                        end else begin
                            sym_err <= 1'b1;
                            let_err <= 1'b1;
                        end
                        state     <= LOW;
                        gap_cnt   <= CNT_ONE;
                        pulse_cnt <= '0;
                    end
                end

                LOW: begin
                    if (i_q) begin
                        state     <= HIGH;
                        pulse_cnt <= CNT_ONE;
                        gap_cnt   <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        letter_valid <= 1'b1;
                        letter_bits  <= sym_buf;
                        letter_len   <= sym_cnt;
                        letter_err   <= let_err;
                        sym_buf      <= '0;
                        sym_cnt      <= '0;
                        let_err      <= 1'b0;
                        gap_cnt      <= '0;
                        state        <= IDLE;
                    end else if (gap_cnt != CNT_MAX) begin
                        gap_cnt <= gap_cnt + CNT_ONE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    pulse_cnt <= '0;
                    gap_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Testbench for morse_symbol_decoder: event-timed reference model of pulses, gaps and letters.
module tb_morse_symbol_decoder;

    localparam int MAX_SYM    = 6;
    localparam int LETTER_GAP = 3;
    localparam int DOT_MAX    = 1;
    localparam int DASH_MIN   = 3;
`ifdef MORSE_GLITCH_FILTER_EN
    localparam int LAT     = 3;
    localparam int MIN_RUN = 2;
`else
    localparam int LAT     = 0;
    localparam int MIN_RUN = 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       I = 1'b0;
    logic       pulse_start;
    logic       dot;
    logic       dash;
    logic       sym_err;
    logic       letter_valid;
    logic [5:0] letter_bits;
    logic [2:0] letter_len;
    logic       letter_err;

    morse_symbol_decoder #(
        .CNT_W(8),
        .DOT_MAX(DOT_MAX),
        .DASH_MIN(DASH_MIN),
        .LETTER_GAP(LETTER_GAP),
        .MAX_SYM(MAX_SYM)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .I(I),
        .pulse_start(pulse_start),
        .dot(dot),
        .dash(dash),
        .sym_err(sym_err),
        .letter_valid(letter_valid),
        .letter_bits(letter_bits),
        .letter_len(letter_len),
        .letter_err(letter_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned t;
        int          kind;
    } sym_ev_t;

    typedef struct {
        int unsigned t;
        logic [5:0]  bits;
        int unsigned len;
        logic        err;
    } let_ev_t;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    sym_ev_t     exp_sym[$];
    sym_ev_t     act_sym[$];
    let_ev_t     exp_let[$];
    let_ev_t     act_let[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // kind: 0 dot, 1 dash, 2 invalid
    always @(posedge CLK) begin
        #1;
        if (dot)     act_sym.push_back('{cyc, 0});
        if (dash)    act_sym.push_back('{cyc, 1});
        if (sym_err) act_sym.push_back('{cyc, 2});
        if (letter_valid) act_let.push_back('{cyc, letter_bits, 32'(letter_len), letter_err});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Pulse k is hi[k] high samples followed by lo[k] low samples; expected events
    // are time-stamped by the edge that samples the relevant input.
    task automatic play(input int unsigned hi[$], input int unsigned lo[$]);
        int unsigned base;
        int unsigned pos;
        int unsigned n;
        int          kind;
        logic [5:0]  lb;
        logic        lerr;
        @(negedge CLK);
        exp_sym.delete(); act_sym.delete(); exp_let.delete(); act_let.delete();
        base = cyc + 1;
        pos  = 0;
        n    = 0;
        lb   = '0;
        lerr = 1'b0;
        for (int k = 0; k < hi.size(); k++) begin
            pos += hi[k];
            kind = (hi[k] <= DOT_MAX) ? 0 : ((hi[k] >= DASH_MIN) ? 1 : 2);
            exp_sym.push_back('{base + pos + LAT, kind});
            if (kind == 2) lerr = 1'b1;
            else if (n < MAX_SYM) begin
                lb[n] = (kind == 1);
                n++;
            end else lerr = 1'b1;
            if (lo[k] >= LETTER_GAP) begin
                exp_let.push_back('{base + pos + LETTER_GAP - 1 + LAT, lb, n, lerr});
                n = 0; lb = '0; lerr = 1'b0;
            end
            pos += lo[k];
        end
        for (int k = 0; k < hi.size(); k++) begin
            repeat (hi[k]) begin I = 1'b1; @(negedge CLK); end
            repeat (lo[k]) begin I = 1'b0; @(negedge CLK); end
        end
        I = 1'b0;
        repeat (LAT + 3) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        RESET = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            I = 1'($urandom_range(0, 1));
            #1;
            obs = {dot, dash, sym_err, letter_valid, letter_err, letter_bits, letter_len};
            n_checks++;
            if (obs !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h required 0", obs);
            end
`ifndef MORSE_GLITCH_FILTER_EN
            n_checks++;
            if (pulse_start !== I) begin
                n_fail++;
                $display("FAIL reset_pulse_start: got %b required %b", pulse_start, I);
            end
`endif
        end
        @(negedge CLK);
        I = 1'b0;
        RESET = 1'b0;
        act_sym.delete(); act_let.delete();
        repeat (4) @(negedge CLK);
        obs = {dot, dash, sym_err, letter_valid, letter_err, letter_bits, letter_len};
        n_checks++;
        if (obs !== 14'd0 || act_sym.size() != 0 || act_let.size() != 0) begin
            n_fail++;
            $display("FAIL reset_release: got outputs %h strobes %0d letters %0d required 0/0/0",
                     obs, act_sym.size(), act_let.size());
        end
    endtask

    task automatic test_directed();
        int unsigned hi[$];
        int unsigned lo[$];
        let_ev_t     last;
`ifndef MORSE_GLITCH_FILTER_EN
        // E, A, invalid-only letter, saturated dash, seven dots (overflow)
        hi = '{1, 1, 3, 2, 257, 1, 1, 1, 1, 1, 1, 1};
        lo = '{3, 1, 3, 3, 3,   1, 1, 1, 1, 1, 1, 3};
`else
        hi = '{2, 3, 4, 257, 2, 2};
        lo = '{3, 2, 3, 3,   2, 4};
`endif
        play(hi, lo);
        n_checks++;
        if (act_sym.size() != exp_sym.size()) begin
            n_fail++;
            $display("FAIL directed_sym_count: got %0d required %0d", act_sym.size(), exp_sym.size());
        end
        for (int k = 0; k < exp_sym.size() && k < act_sym.size(); k++) begin
            n_checks++;
            if (act_sym[k].t !== exp_sym[k].t || act_sym[k].kind !== exp_sym[k].kind) begin
                n_fail++;
                $display("FAIL directed_sym[%0d]: got t=%0d kind=%0d required t=%0d kind=%0d",
                         k, act_sym[k].t, act_sym[k].kind, exp_sym[k].t, exp_sym[k].kind);
            end
        end
        n_checks++;
        if (act_let.size() != exp_let.size()) begin
            n_fail++;
            $display("FAIL directed_letter_count: got %0d required %0d", act_let.size(), exp_let.size());
        end
        for (int k = 0; k < exp_let.size() && k < act_let.size(); k++) begin
            n_checks++;
            if (act_let[k].t !== exp_let[k].t || act_let[k].bits !== exp_let[k].bits ||
                act_let[k].len !== exp_let[k].len || act_let[k].err !== exp_let[k].err) begin
                n_fail++;
                $display("FAIL directed_letter[%0d]: got t=%0d bits=%b len=%0d err=%b required t=%0d bits=%b len=%0d err=%b",
                         k, act_let[k].t, act_let[k].bits, act_let[k].len, act_let[k].err,
                         exp_let[k].t, exp_let[k].bits, exp_let[k].len, exp_let[k].err);
            end
        end
        last = exp_let[exp_let.size() - 1];
        n_checks++;
        if ({letter_bits, letter_len, letter_err} !== {last.bits, last.len[2:0], last.err}) begin
            n_fail++;
            $display("FAIL letter_hold: got bits=%b len=%0d err=%b required bits=%b len=%0d err=%b",
                     letter_bits, letter_len, letter_err, last.bits, last.len, last.err);
        end
    endtask

    task automatic test_reset_midpulse();
        logic [13:0] obs;
        @(negedge CLK);
        I = 1'b1;
        repeat (2) @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        obs = {dot, dash, sym_err, letter_valid, letter_err, letter_bits, letter_len};
        n_checks++;
        if (obs !== 14'd0) begin
            n_fail++;
            $display("FAIL midpulse_reset_clear: got %h required 0", obs);
        end
        act_sym.delete(); act_let.delete();
        repeat (2) @(negedge CLK);
        I = 1'b0;
        RESET = 1'b0;
        repeat (6 + LAT) @(negedge CLK);
        n_checks++;
        if (act_sym.size() != 0 || act_let.size() != 0) begin
            n_fail++;
            $display("FAIL midpulse_reset_strobes: got %0d strobes %0d letters required 0/0",
                     act_sym.size(), act_let.size());
        end
    endtask

`ifndef MORSE_GLITCH_FILTER_EN
    task automatic test_pulse_start();
        @(negedge CLK);
        I = 1'b0;
        #1;
        n_checks++;
        if (pulse_start !== 1'b0) begin
            n_fail++; $display("FAIL pulse_start_idle_low: got %b required 0", pulse_start);
        end
        I = 1'b1;
        #1;
        n_checks++;
        if (pulse_start !== 1'b1) begin
            n_fail++; $display("FAIL pulse_start_idle_high: got %b required 1", pulse_start);
        end
        @(negedge CLK);
        #1;
        n_checks++;
        if (pulse_start !== 1'b0) begin
            n_fail++; $display("FAIL pulse_start_in_pulse: got %b required 0", pulse_start);
        end
        I = 1'b0;
        @(negedge CLK);
        I = 1'b1;
        #1;
        n_checks++;
        if (pulse_start !== 1'b1) begin
            n_fail++; $display("FAIL pulse_start_in_gap: got %b required 1", pulse_start);
        end
        I = 1'b0;
        repeat (LETTER_GAP + 2) @(negedge CLK);
    endtask
`else
    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        @(negedge CLK);
        act_sym.delete(); act_let.delete();
        I = 1'b1;
        @(negedge CLK);
        I = 1'b0;
        repeat (10) begin
            #1 seen |= pulse_start;
            @(negedge CLK);
        end
        n_checks++;
        if (act_sym.size() != 0 || act_let.size() != 0 || seen !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_ignored: got %0d strobes %0d letters pulse_start=%b required 0/0/0",
                     act_sym.size(), act_let.size(), seen);
        end
    endtask
`endif

    task automatic test_random();
        int unsigned hi[$];
        int unsigned lo[$];
        int unsigned np;
        int unsigned h;
        for (int l = 0; l < 25; l++) begin
            np = $urandom_range(1, 8);
            for (int p = 0; p < np; p++) begin
                if ($urandom_range(0, 30) == 0) h = 257;
                else if ($urandom_range(0, 2) == 0) h = MIN_RUN;
                else h = $urandom_range(MIN_RUN, 6);
                hi.push_back(h);
                if (p == np - 1) lo.push_back(LETTER_GAP + $urandom_range(0, 3));
                else lo.push_back($urandom_range(MIN_RUN, LETTER_GAP - 1));
            end
        end
        play(hi, lo);
        n_checks++;
        if (act_sym.size() != exp_sym.size()) begin
            n_fail++;
            $display("FAIL random_sym_count: got %0d required %0d", act_sym.size(), exp_sym.size());
        end
        for (int k = 0; k < exp_sym.size() && k < act_sym.size(); k++) begin
            n_checks++;
            if (act_sym[k].t !== exp_sym[k].t || act_sym[k].kind !== exp_sym[k].kind) begin
                n_fail++;
                $display("FAIL random_sym[%0d]: got t=%0d kind=%0d required t=%0d kind=%0d",
                         k, act_sym[k].t, act_sym[k].kind, exp_sym[k].t, exp_sym[k].kind);
            end
        end
        n_checks++;
        if (act_let.size() != exp_let.size()) begin
            n_fail++;
            $display("FAIL random_letter_count: got %0d required %0d", act_let.size(), exp_let.size());
        end
        for (int k = 0; k < exp_let.size() && k < act_let.size(); k++) begin
            n_checks++;
            if (act_let[k].t !== exp_let[k].t || act_let[k].bits !== exp_let[k].bits ||
                act_let[k].len !== exp_let[k].len || act_let[k].err !== exp_let[k].err) begin
                n_fail++;
                $display("FAIL random_letter[%0d]: got t=%0d bits=%b len=%0d err=%b required t=%0d bits=%b len=%0d err=%b",
                         k, act_let[k].t, act_let[k].bits, act_let[k].len, act_let[k].err,
                         exp_let[k].t, exp_let[k].bits, exp_let[k].len, exp_let[k].err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_midpulse();
`ifndef MORSE_GLITCH_FILTER_EN
        test_pulse_start();
`else
        test_glitch();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_symbol_decoder.md
Name: morse_symbol_decoder

Overview:
- Parametrised successor to the single-cycle dot detector.
- Measures the length of each high pulse on a serial keyed input and classifies it as dot, dash or invalid.
- Measures low gaps between pulses, collects symbols into a letter buffer and emits a completed letter code when an inter-letter gap is seen.
- Sits between the keyed-input front end and the character lookup stage.

Parameters:
- CNT_W, 8: width of the pulse and gap counters; counters saturate at 2^CNT_W-1.
- DOT_MAX, 1: high-pulse length in cycles at or below which the pulse is a dot.
- DASH_MIN, 3: high-pulse length at or above which the pulse is a dash. Required: 1 <= DOT_MAX < DASH_MIN <= 2^CNT_W-1.
- LETTER_GAP, 3: consecutive low cycles that close a letter. Required: LETTER_GAP >= 2.
- MAX_SYM, 6: capacity of the symbol buffer.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- I  input  1  keyed serial input, synchronous to CLK.
- pulse_start  output  1  combinational; high when the block is in IDLE or LOW and the qualified input is 1.
- dot  output  1  registered one-cycle strobe: a dot was classified.
- dash  output  1  registered one-cycle strobe: a dash was classified.
- sym_err  output  1  registered one-cycle strobe: pulse length was strictly between DOT_MAX and DASH_MIN.
- letter_valid  output  1  registered one-cycle strobe: a letter was completed.
- letter_bits  output  MAX_SYM  letter symbols; first symbol in bit 0; dash=1, dot=0; unused bits 0. Valid while letter_valid=1.
- letter_len  output  $clog2(MAX_SYM+1)  number of symbols in the letter.
- letter_err  output  1  letter contained an invalid pulse or overflowed the buffer. Valid with letter_valid.

Behaviour:
- Reset: state=IDLE; counters, symbol buffer, symbol count and error flag cleared. All registered outputs 0 asynchronously on RESET; pulse_start follows I.
- IDLE, I=1: go to HIGH, pulse counter <= 1.
- IDLE, I=0: stay in IDLE.
- HIGH, I=1: pulse counter increments, saturating at 2^CNT_W-1.
- HIGH, I=0 (pulse ends): classify len = pulse counter.
  - len <= DOT_MAX: dot.
  - len >= DASH_MIN: dash. A saturated counter classifies as dash.
  - otherwise: sym_err; the letter error flag is set; no symbol is appended.
  - Then go to LOW with gap counter <= 1.
- Strobe timing: dot, dash and sym_err assert for exactly the one cycle following the edge that sampled the terminating low.
- Append: a dot or dash writes bit index = symbol count, and the count increments.
- Overflow: if symbol count = MAX_SYM, the symbol is discarded, the error flag is set, and the dot/dash strobe still fires.
- LOW, I=1: go to HIGH, pulse counter <= 1; gap counter cleared.
- LOW, I=0: gap counter increments. On the edge where it would reach LETTER_GAP:
  - register letter_bits, letter_len and letter_err;
  - pulse letter_valid for one cycle;
  - clear buffer, count and error flag;
  - go to IDLE.
- A letter of zero symbols is possible (all pulses invalid); it is emitted with letter_len=0 and letter_err=1.
- letter_bits, letter_len and letter_err hold their last values until the next letter completes.
- Letter emission and a new pulse cannot coincide: I=1 in LOW always preempts the gap.
- RESET mid-pulse or mid-letter: everything is discarded immediately; no strobes fire.
- State encoding is 2 bits; the unused code recovers to IDLE on the next edge.

Optional Feature:
- Macro: MORSE_GLITCH_FILTER_EN.
- Defined: I passes through a 2-flop stage and a qualifier. The qualified input changes only after 2 consecutive equal samples. Every response, including pulse_start, is based on the qualified input and lags raw I by 3 cycles. Single-cycle glitches are ignored entirely.
- Undefined: I is used directly with no added latency; DOT_MAX=1 single-cycle pulses are legal dots.

Test Plan:
- Defaults, MORSE_GLITCH_FILTER_EN undefined, unless noted.
1. RESET high, I toggling -> all registered outputs 0, no strobes; release with I=0 -> IDLE, still all 0.
2. I=1 for 1 cycle, then I=0 for 3 cycles -> dot strobe 1 cycle after the fall; letter_valid with letter_bits=6'b000000, letter_len=1, letter_err=0 ("E").
3. I=1 for 1, 0 for 1, 1 for 3, 0 for 3 -> dot, then dash; letter_bits=6'b000010, letter_len=2, letter_err=0 ("A").
4. I=1 for 2 cycles, then 0 for 3 -> sym_err strobe; letter_valid with letter_len=0, letter_err=1.
5. Seven 1-cycle pulses, each followed by 1 low cycle, then 3 low cycles -> seven dot strobes; letter_len=6, letter_bits=0, letter_err=1.
6. Assert RESET after 2 high cycles of a dash -> outputs clear immediately, no dash or letter strobe.
   Rerun with MORSE_GLITCH_FILTER_EN defined and a 1-cycle pulse -> no strobes at all.
